// File: rtl/prim_oh_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered select stage (one-hot, index, valid)
// for a downstream onehot checker; a checker error latches a sticky fatal and stops arbitration.
module prim_oh_rr_arbiter #(
    parameter int N     = 8,
    parameter int IdxW  = 3,
    parameter int DataW = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    input  logic [N*DataW-1:0]   data_i,
    output logic [N-1:0]         gnt_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataW-1:0]     data_o,
    output logic [IdxW-1:0]      idx_o,
    output logic [N-1:0]         oh_o,
    input  logic                 chk_err_i,
    output logic                 fatal_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e             state_q, state_d;
    logic               valid_q;
    logic [DataW-1:0]   data_q, data_d, data_sel;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [IdxW-1:0]    ptr_q, ptr_d, ptr_next;
    logic [IdxW-1:0]    win, cand_idx;
    logic [N-1:0]       oh_q, oh_d, oh_sel, req_rot;
    logic               fatal_q;
    logic               accept, found, grant;
    int                 cand;

    assign valid_q = (state_q == FULL);
    assign accept  = !fatal_q && (!valid_q || ready_i);

    // Scan ptr_q, ptr_q+1, ... wrapping at N (not 2**IdxW) for the first request.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        req_rot  = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = cand[IdxW-1:0];
            req_rot  = req_i >> cand_idx;
            if (!found && req_rot[0]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    always_comb begin
        oh_sel    = '0;
        oh_sel[0] = 1'b1;
        oh_sel    = oh_sel << win;
        data_sel  = DataW'(data_i >> (int'(win) * DataW));
        if (int'(win) == N - 1) ptr_next = '0;
        else                    ptr_next = win + 1'b1;
    end

    // Reset gates the grant so nothing transfers while the stage is held in reset.
    assign grant = accept && found && rst_ni;
    assign gnt_o = grant ? oh_sel : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = FULL;
            data_d  = data_sel;
            idx_d   = win;
            oh_d    = oh_sel;
            ptr_d   = ptr_next;
        end else if (!fatal_q && valid_q && ready_i) begin
            state_d = EMPTY;
            oh_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            ptr_q   <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
            fatal_q <= fatal_q | chk_err_i;
        end
    end

    assign valid_o = valid_q && !fatal_q;
    assign oh_o    = oh_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;
    assign fatal_o = fatal_q;

endmodule
